regfile_wb_queue: RTL and testbench
===================================

// Module: regfile_wb_queue
// PURPOSE
//  Writer side of the integer register file: buffers write-back results from the execute/load
//  path and drains them, one per cycle, onto the register-file write port (wr_en/wr_addr/wr_data).
//  It also returns forwarded values for rs1/rs2. A write stays visible to readers while it waits
//  in the queue, or sits on the output stage not yet committed to the array.
//  Sits between the write-back stage and regfile_int.
// PARAMETERS
//  DEPTH   4   queue entries; power of two, >=2
//  PTR_W   $clog2(DEPTH)   localparam, pointer width; count is PTR_W+1 bits
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst_n      in   1      asynchronous, active-low reset
//  wb_valid   in   1      write-back request valid
//  wb_ready   out  1      queue can accept; transfer when wb_valid && wb_ready
//  wb_rd      in   5      destination register
//  wb_data    in   32     result value
//  drain_en   in   1      regfile write port available this cycle; 0 = stall drain
//  wr_en      out  1      registered; to regfile write enable
//  wr_addr    out  5      registered; to regfile write address
//  wr_data    out  32     registered; to regfile write data
//  rs1_addr   in   5      forward lookup address 1
//  rs1_hit    out  1      pending write to rs1_addr exists
//  rs1_fwd    out  32     youngest pending value for rs1_addr (0 when no hit)
//  rs2_addr   in   5      forward lookup address 2
//  rs2_hit    out  1      as rs1
//  rs2_fwd    out  32     as rs1
//  count      out  PTR_W+1  entries currently queued, excluding the output stage
// BEHAVIOUR
//  Reset (async, rst_n=0): head=tail=0; count=0; all entry valid bits=0; wr_en=0; wr_addr=0;
//   wr_data=0. Queued writes are discarded on reset mid-operation. Entry payloads are not reset.
//  wb_ready = (count != DEPTH). It is derived from registered count only; a same-cycle pop
//   never raises it.
//  Push: on a transfer with wb_rd != 0, write {wb_rd, wb_data} at tail and increment tail
//   modulo DEPTH. A transfer with wb_rd == 0 is accepted and dropped; count is unchanged.
//  Pop: at each posedge, if drain_en && count != 0: wr_en<=1, wr_addr/wr_data<=head entry, and
//   head increments modulo DEPTH. Otherwise wr_en<=0 and wr_addr/wr_data hold their values.
//  Ordering is strictly FIFO, so repeated writes to the same rd commit in acceptance order.
//  Latency, empty queue with drain_en=1: accepted at edge N -> wr_en high from edge N+1 for
//   exactly one cycle -> the regfile array is updated at edge N+2.
//  Simultaneous push and pop: count unchanged, and both pointers advance.
//  Full (count == DEPTH): wb_ready=0. No push occurs that cycle, even if a pop occurs.
//  Forwarding is combinational from registered state only; wb_* inputs are not bypassed.
//   Candidates, youngest first: valid queue entries from tail-1 back to head, then the output
//   stage (wr_en=1). The first candidate whose rd matches the address supplies the value:
//   hit=1, fwd=data. With no match, or when the address is 0: hit=0, fwd=32'h0.
//  Pointer wrap: tail and head wrap independently, and count alone distinguishes full from empty.
// STRUCTURE
//  Shared package rv_core_pkg:
//   XLEN=32, REG_AW=5
//   typedef struct packed {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;} wb_entry_t
//  Sub-module wb_fwd_match: DEPTH entries + valid mask + head/tail + output stage + lookup
//   address in; hit and fwd out, youngest-first priority. Instantiated twice, for rs1 and rs2.
//  Top level keeps the storage, pointers, count and output register.
// TESTING
//  1 Reset mid-stream: count=3, rst_n=0 -> wr_en=0, count=0, wb_ready=1, rs1_hit=0 immediately.
//  2 Single write rd=5, data=32'hDEADBEEF, drain_en=1, accepted at edge N -> wr_en=1, wr_addr=5,
//    wr_data=DEADBEEF for the cycle after edge N+1 only; rs1_addr=5 gives hit=1, fwd=DEADBEEF
//    from edge N up to edge N+2.
//  3 wb_rd=0, data=32'h1234 -> wb_ready=1, count stays 0, wr_en never asserts, rs1_addr=0 hit=0.
//  4 drain_en=0, push rd=1..5 back-to-back -> 4 accepted, wb_ready=0 on the 5th. Then drain_en=1
//    -> wr_addr 1,2,3,4 on consecutive cycles; the 5th is accepted the cycle after count drops.
//  5 drain_en=0, push rd=7 data=1 then rd=7 data=2 -> rs2_fwd=2. Pulse drain_en for one pop
//    -> wr_data=1 on the port while rs2_fwd stays 2.
//  6 count=3, wb_valid=1, drain_en=1 -> push and pop in the same edge, count stays 3, and the
//    tail wraps 3->0 correctly.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core types: register-file geometry and the write-back entry carried
// from execute/load through the write-back queue into the register file.
package rv_core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // x0 is hardwired to zero, so a result aimed at it never needs committing.
    function automatic logic rd_is_writable(input logic [REG_AW-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding lookup over the write-back queue: returns the youngest pending
// value for one register address, searching queued entries before the output stage.
module wb_fwd_match
    import rv_core_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] i_entries,
    input  logic [DEPTH-1:0]      i_valid,
    input  logic [PTR_W-1:0]      i_tail,
    input  logic                  i_out_valid,
    input  wb_entry_t             i_out_entry,
    input  logic [REG_AW-1:0]     i_addr,
    output logic                  o_hit,
    output logic [XLEN-1:0]       o_fwd
);

    // Candidate gi is the entry gi+1 slots behind the tail, so gi=0 is the youngest.
    logic [DEPTH-1:0]      w_match;
    logic [XLEN-1:0]       w_cand_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] w_idx;
            assign w_idx           = i_tail - PTR_W'(gi + 1);
            assign w_match[gi]     = i_valid[w_idx] && (i_entries[w_idx].rd == i_addr);
            assign w_cand_data[gi] = i_entries[w_idx].data;
        end
    endgenerate

    // Oldest candidate is considered first so each younger match overrides it.
    always_comb begin
        o_hit = 1'b0;
        o_fwd = '0;
        if (i_addr != '0) begin
            if (i_out_valid && (i_out_entry.rd == i_addr)) begin
                o_hit = 1'b1;
                o_fwd = i_out_entry.data;
            end
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (w_match[k]) begin
                    o_hit = 1'b1;
                    o_fwd = w_cand_data[k];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the integer register file: buffers results,
// drains one per cycle onto the write port, and forwards pending values to readers.
module regfile_wb_queue
    import rv_core_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wb_valid,
    output logic              o_wb_ready,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic              i_drain_en,
    output logic              o_wr_en,
    output logic [REG_AW-1:0] o_wr_addr,
    output logic [XLEN-1:0]   o_wr_data,
    input  logic [REG_AW-1:0] i_rs1_addr,
    output logic              o_rs1_hit,
    output logic [XLEN-1:0]   o_rs1_fwd,
    input  logic [REG_AW-1:0] i_rs2_addr,
    output logic              o_rs2_hit,
    output logic [XLEN-1:0]   o_rs2_fwd,
    output logic [PTR_W:0]    o_count
);

    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_wr_en;
    wb_entry_t          r_out;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    wb_entry_t [DEPTH-1:0] w_entries;

    // Readiness comes from the registered count only, so a full queue refuses
    // a push even in a cycle where it also pops.
    assign w_ready = (r_count != CNT_W'(DEPTH));
    assign w_push  = i_wb_valid && w_ready && rd_is_writable(i_wb_rd);
    assign w_pop   = i_drain_en && (r_count != '0);

    // Payloads carry no reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{rd: i_wb_rd, data: i_wb_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_wr_en <= 1'b0;
            r_out   <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
                r_out           <= r_mem[r_head];
            end
            r_wr_en <= w_pop;
            // Push and pop never target the same slot: that needs full and empty at once.
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pack
            assign w_entries[gi] = r_mem[gi];
        end
    endgenerate

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs1 (
        .i_entries   (w_entries),
        .i_valid     (r_valid),
        .i_tail      (r_tail),
        .i_out_valid (r_wr_en),
        .i_out_entry (r_out),
        .i_addr      (i_rs1_addr),
        .o_hit       (o_rs1_hit),
        .o_fwd       (o_rs1_fwd)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs2 (
        .i_entries   (w_entries),
        .i_valid     (r_valid),
        .i_tail      (r_tail),
        .i_out_valid (r_wr_en),
        .i_out_entry (r_out),
        .i_addr      (i_rs2_addr),
        .o_hit       (o_rs2_hit),
        .o_fwd       (o_rs2_fwd)
    );

    assign o_wb_ready = w_ready;
    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_out.rd;
    assign o_wr_data  = r_out.data;
    assign o_count    = r_count;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: hand-checked vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_wb_valid;
    logic        o_wb_ready;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        i_drain_en;
    logic        o_wr_en;
    logic [4:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic [4:0]  i_rs1_addr;
    logic        o_rs1_hit;
    logic [31:0] o_rs1_fwd;
    logic [4:0]  i_rs2_addr;
    logic        o_rs2_hit;
    logic [31:0] o_rs2_fwd;
    logic [2:0]  o_count;

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wb_valid (i_wb_valid),
        .o_wb_ready (o_wb_ready),
        .i_wb_rd    (i_wb_rd),
        .i_wb_data  (i_wb_data),
        .i_drain_en (i_drain_en),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .i_rs1_addr (i_rs1_addr),
        .o_rs1_hit  (o_rs1_hit),
        .o_rs1_fwd  (o_rs1_fwd),
        .i_rs2_addr (i_rs2_addr),
        .o_rs2_hit  (o_rs2_hit),
        .o_rs2_fwd  (o_rs2_fwd),
        .o_count    (o_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending writes in acceptance order plus the port stage.
    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        m_q[$];
    logic        m_wr_en;
    logic [4:0]  m_wr_addr;
    logic [31:0] m_wr_data;

    typedef struct {
        logic wv; logic [4:0] rd; logic [31:0] data; logic dr; logic [4:0] a1;
        logic [2:0] cnt; logic rdy; logic en; logic [4:0] wa; logic [31:0] wd;
        logic hit; logic [31:0] fwd;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
    endfunction

    // Youngest pending write wins: search queue from newest back, then the port stage.
    function automatic void model_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 0) begin
            for (int i = m_q.size() - 1; i >= 0 && !h; i--) begin
                if (m_q[i].rd == a) begin
                    h = 1'b1;
                    d = m_q[i].data;
                end
            end
            if (!h && m_wr_en && m_wr_addr == a) begin
                h = 1'b1;
                d = m_wr_data;
            end
        end
    endfunction

    // One clock: drive inputs, check against the model before the edge, advance the model,
    // then return one time unit after the following falling edge.
    task automatic step(input logic wv, input logic [4:0] rd, input logic [31:0] data,
                        input logic dr, input logic [4:0] a1, input logic [4:0] a2);
        logic        h;
        logic [31:0] d;
        logic        rdy;
        logic        pop;
        i_wb_valid = wv;
        i_wb_rd    = rd;
        i_wb_data  = data;
        i_drain_en = dr;
        i_rs1_addr = a1;
        i_rs2_addr = a2;
        #1;
        rdy = (m_q.size() != 4);
        chk("wb_ready", 32'(o_wb_ready), 32'(rdy));
        chk("count", 32'(o_count), 32'(m_q.size()));
        chk("wr_en", 32'(o_wr_en), 32'(m_wr_en));
        chk("wr_addr", 32'(o_wr_addr), 32'(m_wr_addr));
        chk("wr_data", o_wr_data, m_wr_data);
        model_fwd(a1, h, d);
        chk("rs1_hit", 32'(o_rs1_hit), 32'(h));
        chk("rs1_fwd", o_rs1_fwd, d);
        model_fwd(a2, h, d);
        chk("rs2_hit", 32'(o_rs2_hit), 32'(h));
        chk("rs2_fwd", o_rs2_fwd, d);
        pop = dr && (m_q.size() != 0);
        if (pop) begin
            m_wr_en   = 1'b1;
            m_wr_addr = m_q[0].rd;
            m_wr_data = m_q[0].data;
            void'(m_q.pop_front());
        end else begin
            m_wr_en = 1'b0;
        end
        if (wv && rdy && rd != 0) m_q.push_back('{rd: rd, data: data});
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        i_wb_valid = 1'b0;
        i_drain_en = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        i_wb_valid = 1'b0;
        i_wb_rd    = '0;
        i_wb_data  = '0;
        i_drain_en = 1'b0;
        i_rs1_addr = '0;
        i_rs2_addr = '0;
        model_reset();

        tv[0]  = '{1'b1, 5'd1, 32'd101, 1'b0, 5'd1, 3'd1, 1'b1, 1'b0, 5'd0, 32'd0,   1'b1, 32'd101};
        tv[1]  = '{1'b1, 5'd2, 32'd102, 1'b0, 5'd2, 3'd2, 1'b1, 1'b0, 5'd0, 32'd0,   1'b1, 32'd102};
        tv[2]  = '{1'b1, 5'd3, 32'd103, 1'b0, 5'd1, 3'd3, 1'b1, 1'b0, 5'd0, 32'd0,   1'b1, 32'd101};
        tv[3]  = '{1'b1, 5'd4, 32'd104, 1'b0, 5'd4, 3'd4, 1'b0, 1'b0, 5'd0, 32'd0,   1'b1, 32'd104};
        tv[4]  = '{1'b1, 5'd5, 32'd105, 1'b0, 5'd5, 3'd4, 1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 32'd0};
        tv[5]  = '{1'b1, 5'd5, 32'd105, 1'b1, 5'd1, 3'd3, 1'b1, 1'b1, 5'd1, 32'd101, 1'b1, 32'd101};
        tv[6]  = '{1'b1, 5'd5, 32'd105, 1'b1, 5'd5, 3'd3, 1'b1, 1'b1, 5'd2, 32'd102, 1'b1, 32'd105};
        tv[7]  = '{1'b0, 5'd0, 32'd0,   1'b1, 5'd3, 3'd2, 1'b1, 1'b1, 5'd3, 32'd103, 1'b1, 32'd103};
        tv[8]  = '{1'b0, 5'd0, 32'd0,   1'b1, 5'd2, 3'd1, 1'b1, 1'b1, 5'd4, 32'd104, 1'b0, 32'd0};
        tv[9]  = '{1'b0, 5'd0, 32'd0,   1'b1, 5'd5, 3'd0, 1'b1, 1'b1, 5'd5, 32'd105, 1'b1, 32'd105};
        tv[10] = '{1'b0, 5'd0, 32'd0,   1'b1, 5'd5, 3'd0, 1'b1, 1'b0, 5'd5, 32'd105, 1'b0, 32'd0};
        tv[11] = '{1'b1, 5'd0, 32'h1234,1'b1, 5'd0, 3'd0, 1'b1, 1'b0, 5'd5, 32'd105, 1'b0, 32'd0};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_wr_en", 32'(o_wr_en), 32'd0);
        chk("reset_count", 32'(o_count), 32'd0);
        chk("reset_ready", 32'(o_wb_ready), 32'd1);
        chk("reset_wr_addr", 32'(o_wr_addr), 32'd0);
        chk("reset_wr_data", o_wr_data, 32'd0);
        rst_n = 1'b1;

        // Reset mid-stream with three queued and one on the port.
        step(1'b1, 5'd1, 32'h11, 1'b0, 5'd1, 5'd0);
        step(1'b1, 5'd2, 32'h22, 1'b0, 5'd1, 5'd0);
        step(1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 5'd0);
        step(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 5'd0);
        chk("mid_count", 32'(o_count), 32'd3);
        chk("mid_wr_en", 32'(o_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(o_wr_en), 32'd0);
        chk("arst_count", 32'(o_count), 32'd0);
        chk("arst_ready", 32'(o_wb_ready), 32'd1);
        chk("arst_rs1_hit", 32'(o_rs1_hit), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Single write latency and forwarding window.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd0);
        chk("single_q_hit", 32'(o_rs1_hit), 32'd1);
        chk("single_q_fwd", o_rs1_fwd, 32'hDEADBEEF);
        chk("single_q_wr_en", 32'(o_wr_en), 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);
        chk("single_wr_en", 32'(o_wr_en), 32'd1);
        chk("single_wr_addr", 32'(o_wr_addr), 32'd5);
        chk("single_wr_data", o_wr_data, 32'hDEADBEEF);
        chk("single_out_hit", 32'(o_rs1_hit), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);
        chk("single_done_wr_en", 32'(o_wr_en), 32'd0);
        chk("single_done_hit", 32'(o_rs1_hit), 32'd0);

        // Same rd twice: youngest forwarded, oldest committed first.
        do_reset();
        step(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 5'd7);
        step(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 5'd7);
        chk("dup_rs2_fwd", o_rs2_fwd, 32'd2);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd7);
        chk("dup_wr_data", o_wr_data, 32'd1);
        chk("dup_rs2_fwd_after_pop", o_rs2_fwd, 32'd2);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7);

        // Push and pop together at count 3 with the tail wrapping.
        do_reset();
        step(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd11, 32'hA1, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd12, 32'hA2, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd13, 32'hA3, 1'b1, 5'd13, 5'd0);
        chk("wrap_count", 32'(o_count), 32'd3);
        chk("wrap_wr_addr", 32'(o_wr_addr), 32'd10);
        step(1'b1, 5'd14, 32'hA4, 1'b1, 5'd14, 5'd13);
        chk("wrap2_count", 32'(o_count), 32'd3);
        chk("wrap2_rs1_fwd", o_rs1_fwd, 32'hA4);
        for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 5'd12);

        // Table: fill to full, refused fifth push, drain in order, rd=0 drop.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tv[i].wv, tv[i].rd, tv[i].data, tv[i].dr, tv[i].a1, 5'd0);
            chk($sformatf("tv%0d_count", i), 32'(o_count), 32'(tv[i].cnt));
            chk($sformatf("tv%0d_ready", i), 32'(o_wb_ready), 32'(tv[i].rdy));
            chk($sformatf("tv%0d_wr_en", i), 32'(o_wr_en), 32'(tv[i].en));
            chk($sformatf("tv%0d_wr_addr", i), 32'(o_wr_addr), 32'(tv[i].wa));
            chk($sformatf("tv%0d_wr_data", i), o_wr_data, tv[i].wd);
            chk($sformatf("tv%0d_rs1_hit", i), 32'(o_rs1_hit), 32'(tv[i].hit));
            chk($sformatf("tv%0d_rs1_fwd", i), o_rs1_fwd, tv[i].fwd);
        end

        // Randomized traffic with the drain rate shifting between phases.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic dr;
            case ((i / 100) % 4)
                0:       dr = ($urandom_range(0, 3) == 0);
                1:       dr = ($urandom_range(0, 3) != 0);
                2:       dr = 1'b0;
                default: dr = $urandom_range(0, 1) == 1;
            endcase
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, dr,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
